// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC measurement path.
package tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FLIGHT,
    ST_SAMPLE,
    ST_ENCODE,
    ST_OUT
  } tdc_state_e;

  // Width needed to hold a tap count of 0..n inclusive.
  function automatic int unsigned tdc_res_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tdc_therm_encoder.sv
// Thermometer-to-count encoder: leading-ones count from bit 0 plus bubble detect.
module tdc_therm_encoder #(
  parameter int unsigned N  = 64,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  therm_i,
  output logic [CW-1:0] count_o,
  output logic          bubble_o
);

  logic seen_zero;

  // Count stops at the first 0; any later 1 flags a bubble without correcting the count.
  always_comb begin
    count_o   = '0;
    bubble_o  = 1'b0;
    seen_zero = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!therm_i[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        bubble_o = 1'b1;
      end else begin
        count_o = CW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: drain line, launch pulse, double-capture taps,
// encode, and hand the result out over valid/ready.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned N      = 64,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CW     = tdc_res_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  output logic          pulse_o,
  input  logic [N-1:0]  meas_i,
  output logic [CW-1:0] result_o,
  output logic          bubble_o,
  output logic          clr_err_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          busy_o
);

  localparam int unsigned CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE - 1);

  tdc_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    cap1_q, cap1_d;
  logic [N-1:0]    cap2_q, cap2_d;
  logic            pulse_q, pulse_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   result_q, result_d;
  logic            bubble_q, bubble_d;
  logic            clr_err_q, clr_err_d;

  logic [CW-1:0]   enc_count;
  logic            enc_bubble;

  tdc_therm_encoder #(
    .N  (N),
    .CW (CW)
  ) u_enc (
    .therm_i  (cap2_q),
    .count_o  (enc_count),
    .bubble_o (enc_bubble)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap1_d    = cap1_q;
    cap2_d    = cap2_q;
    pulse_d   = pulse_q;
    valid_d   = valid_q;
    result_d  = result_q;
    bubble_d  = bubble_q;
    clr_err_d = clr_err_q;

    unique case (state_q)
      ST_IDLE: begin
        pulse_d = 1'b0;
        if (start_i) begin
          state_d   = ST_ARM;
          cnt_d     = CNT_LOAD;
          clr_err_d = 1'b0;
        end
      end
      ST_ARM: begin
        // Line must have drained by the last ARM cycle; launch on the same edge.
        if (cnt_q == '0) begin
          clr_err_d = |meas_i;
          pulse_d   = 1'b1;
          state_d   = ST_FLIGHT;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      ST_FLIGHT: begin
        cap1_d  = meas_i;
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        cap2_d  = cap1_q;
        pulse_d = 1'b0;
        state_d = ST_ENCODE;
      end
      ST_ENCODE: begin
        result_d = enc_count;
        bubble_d = enc_bubble;
        valid_d  = 1'b1;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cap1_q    <= '0;
      cap2_q    <= '0;
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      bubble_q  <= 1'b0;
      clr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap1_q    <= cap1_d;
      cap2_q    <= cap2_d;
      pulse_q   <= pulse_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      bubble_q  <= bubble_d;
      clr_err_q <= clr_err_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign bubble_o  = bubble_q;
  assign clr_err_o = clr_err_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl (N=64, SETTLE=2); outputs sampled on negedge.
module tb_tdc_meas_ctrl;

  localparam int unsigned N  = 64;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic          pulse_o;
  logic [N-1:0]  meas_i;
  logic [CW-1:0] result_o;
  logic          bubble_o;
  logic          clr_err_o;
  logic          valid_o;
  logic          ready_i;
  logic          busy_o;

  int n_chk;
  int n_pass;

  tdc_meas_ctrl #(
    .N      (N),
    .SETTLE (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .pulse_o   (pulse_o),
    .meas_i    (meas_i),
    .result_o  (result_o),
    .bubble_o  (bubble_o),
    .clr_err_o (clr_err_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the FSM idle. arm_m is on the taps through the
  // last ARM cycle, fl_m from FLIGHT onward. hold = cycles of ready_i=0 in OUT.
  task automatic run_meas(input logic [63:0] arm_m, input logic [63:0] fl_m,
                          input int exp_res, input logic exp_bub,
                          input logic exp_clr, input int hold);
    start_i = 1'b1;
    meas_i  = arm_m;
    ready_i = (hold == 0);
    tick();                                   // e0: start accepted
    start_i = 1'b0;
    chk("busy_arm", busy_o, 1);
    chk("pulse_e0", pulse_o, 0);
    start_i = 1'b1;                           // ignored while in ARM
    tick();                                   // e1
    start_i = 1'b0;
    chk("pulse_e1", pulse_o, 0);
    tick();                                   // e2: launch
    chk("pulse_rise", pulse_o, 1);
    chk("clr_err_arm", clr_err_o, exp_clr);
    meas_i = fl_m;
    tick();                                   // e3: taps sampled
    chk("pulse_e3", pulse_o, 1);
    chk("valid_e3", valid_o, 0);
    tick();                                   // e4
    chk("pulse_fall", pulse_o, 0);
    chk("valid_e4", valid_o, 0);
    tick();                                   // e5
    chk("valid_rise", valid_o, 1);
    chk("result", result_o, exp_res);
    chk("bubble", bubble_o, exp_bub);
    chk("clr_err_out", clr_err_o, exp_clr);
    for (int h = 0; h < hold; h++) begin
      start_i = h[0];
      meas_i  = {$urandom, $urandom};
      tick();
      chk("bp_valid", valid_o, 1);
      chk("bp_result", result_o, exp_res);
      chk("bp_bubble", bubble_o, exp_bub);
      chk("bp_pulse", pulse_o, 0);
      chk("bp_busy", busy_o, 1);
    end
    ready_i = 1'b1;
    start_i = 1'b1;                           // ignored on the handoff edge
    tick();
    chk("valid_fall", valid_o, 0);
    chk("busy_idle", busy_o, 0);
    start_i = 1'b0;
    tick();
    chk("idle_pulse", pulse_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("result_held", result_o, exp_res);
  endtask

  initial begin
    bit pulse_seen;
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    start_i = 1'($urandom);
    ready_i = 1'($urandom);
    meas_i  = {$urandom, $urandom};
    #23;
    chk("rst_pulse", pulse_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_bubble", bubble_o, 0);
    chk("rst_clr_err", clr_err_o, 0);

    @(negedge clk);
    start_i = 1'b0;
    meas_i  = '0;
    ready_i = 1'b1;
    rst_n   = 1'b1;
    pulse_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulse_seen |= pulse_o | busy_o;
    end
    chk("idle_no_pulse", 64'(pulse_seen), 0);

    run_meas(64'h0, 64'h00FF, 8, 1'b0, 1'b0, 0);
    run_meas(64'h0, 64'h0F0F, 4, 1'b1, 1'b0, 0);
    run_meas(64'h0, '1, 64, 1'b0, 1'b0, 0);
    run_meas(64'h0, 64'h0, 0, 1'b0, 1'b0, 0);
    run_meas(64'h0, 64'h0007, 3, 1'b0, 1'b0, 10);
    run_meas(64'h1, 64'h00FF, 8, 1'b0, 1'b1, 0);
    run_meas(64'h0, 64'h003F, 6, 1'b0, 1'b0, 0);

    // Reset while the pulse is in flight must clear outputs without a clock edge.
    start_i = 1'b1;
    meas_i  = '0;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk("mid_pulse_hi", pulse_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pulse", pulse_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_result", result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_meas(64'h0, 64'h01FF, 9, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the TDC delay line. On a start request it clears the line, launches a single pulse into the delay line input, and captures the line's thermometer taps one clock later through a two-stage capture register. It then encodes the tap pattern into a tap count and presents the result over a valid/ready handshake. It sits between the project top-level (start/readout logic) and the `delay_line` instance, driving the line's `in` and sampling its `dl_out`.

## Interface
- `N`, 64: number of delay-line taps; must match the `delay_line` instance.
- `SETTLE`, 2: cycles `pulse_o` is held low before launch so the line drains. Must be ≥1.
- `CW`, `$clog2(N+1)`: result width; holds 0..N.

- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start_i` in 1: measurement request; sampled only in IDLE.
- `pulse_o` out 1: drives `delay_line.in`.
- `meas_i` in N: `delay_line.dl_out` taps; bit 0 is nearest the input.
- `result_o` out CW: leading-ones count of the captured taps.
- `bubble_o` out 1: a 1 was captured above the first 0.
- `clr_err_o` out 1: line was not all-zero at the end of ARM.
- `valid_o` out 1: result/flags valid.
- `ready_i` in 1: consumer accepts the result.
- `busy_o` out 1: high when state ≠ IDLE.

## Operation
- FSM states: IDLE, ARM, FLIGHT, SAMPLE, ENCODE, OUT.
- IDLE: `pulse_o`=0. If `start_i`=1, go to ARM, load `cnt`=SETTLE-1, and clear `clr_err_o`.
- ARM: `pulse_o`=0 and `cnt` decrements each cycle.
  - When `cnt`==0, set `clr_err_o` to `|meas_i`, set `pulse_o`=1, and go to FLIGHT.
  - ARM lasts exactly SETTLE cycles.
- FLIGHT: the pulse propagates for one clock period. At the edge, `cap1`←`meas_i` and the FSM goes to SAMPLE.
- SAMPLE: `cap2`←`cap1` (metastability stage), `pulse_o`←0, go to ENCODE.
- ENCODE:
  - `result_o`←number of consecutive 1s in `cap2` starting at bit 0.
  - `bubble_o`←any 1 at an index above the first 0.
  - `valid_o`←1, go to OUT.
- OUT: `valid_o`, `result_o`, `bubble_o` and `clr_err_o` are held stable.
  - When `valid_o`&&`ready_i`, set `valid_o`←0 and go to IDLE.
  - `start_i` is ignored in OUT and in every state other than IDLE, including the handoff cycle.
- Boundaries:
  - All ones captured: `result_o`=N. This is overflow; the pulse outran the line.
  - All zeros captured: `result_o`=0.
  - Bubble: `result_o` is still the position of the first 0; no correction is applied.
  - `result_o` keeps its last value through IDLE until the next ENCODE.

## Timing
- Reset (async, `rst_n`=0) immediately forces the following, regardless of state, including mid-flight:
  - state=IDLE
  - `pulse_o`=0, `valid_o`=0, `busy_o`=0
  - `result_o`=0, `bubble_o`=0, `clr_err_o`=0
  - `cnt`=0, `cap1`=`cap2`=0
- Start accepted at edge e0. `pulse_o` rises at e0+SETTLE, taps are sampled at e0+SETTLE+1, `pulse_o` falls at e0+SETTLE+2, and `valid_o` rises at e0+SETTLE+3.
  - With defaults, `valid_o` rises 5 edges after the start edge.
- `pulse_o` is high for exactly 2 cycles per measurement.
- All outputs are registered. `busy_o` decodes the registered state only.
- Minimum start-to-start spacing: SETTLE+5 cycles, with `ready_i` tied high.

## Structure
- Package `tdc_pkg`:
  - `tdc_state_e` enum of the six states.
  - Function `tdc_res_width(N)`.
- Sub-module `tdc_therm_encoder #(N)`: purely combinational, `cap2` → (`count`, `bubble`). It is reused by future readout paths.
- `tdc_meas_ctrl` holds the FSM, `cnt`, the capture registers and the output registers.

## Test plan
- Reset values: assert `rst_n`=0 with random inputs → every output is 0 and `busy_o`=0. Release reset, hold `start_i`=0 for 20 cycles → `pulse_o` stays 0.
- Nominal: N=64, SETTLE=2; `start_i` pulse; `meas_i`=64'h00FF held from FLIGHT onward → `pulse_o` high for edges 2-3 only, `valid_o` at edge 5, `result_o`=8, `bubble_o`=0.
- Bubble and bounds:
  - `meas_i`=64'h0F0F → `result_o`=4, `bubble_o`=1.
  - All ones → `result_o`=64.
  - All zeros → `result_o`=0, `bubble_o`=0.
- Backpressure: `ready_i`=0 for 10 cycles after `valid_o` with `start_i` toggling → outputs stay stable and no new `pulse_o`. Then `ready_i`=1 → `valid_o` falls next edge and the FSM returns to IDLE.
- Clear error: `meas_i`=64'h1 during the last ARM cycle → `clr_err_o`=1 with the result. The next start with a clean line → `clr_err_o`=0.
- Reset mid-FLIGHT: assert `rst_n` while `pulse_o`=1 → `pulse_o`=0 with no clock edge. After release, a new start gives normal 5-cycle latency.
